// File: rtl/mux_sched_pkg.sv
// Shared types and default sizing for the 16:1 round-robin mux scheduler.
package mux_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int unsigned N_REQ_DEF     = 16;
    localparam int unsigned SEL_W_DEF     = 4;
    localparam int unsigned BURST_LEN_DEF = 4;

endpackage

// File: rtl/mux16_rr_scheduler_rr_pick.sv
// Combinational round-robin pick: the first set request after last_ptr, wrapping modulo N_REQ.
module rr_pick
    import mux_sched_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned SEL_W = SEL_W_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last_ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any_req
);

    logic [SEL_W-1:0] start;
    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;
    logic [SEL_W:0]   sum;

    always_comb begin
        start = (last_ptr == SEL_W'(N_REQ - 1)) ? '0 : last_ptr + SEL_W'(1);
        // rot[0] is the request at index start, so the lowest set bit is the next in turn
        rot   = N_REQ'({req, req} >> start);
        off   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rot[N_REQ-1-i]) begin
                off = SEL_W'(N_REQ - 1 - i);
            end
        end
        sum     = {1'b0, start} + {1'b0, off};
        winner  = (sum >= (SEL_W+1)'(N_REQ)) ? SEL_W'(sum - (SEL_W+1)'(N_REQ)) : sum[SEL_W-1:0];
        any_req = |req;
    end

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin sequencer sharing one mux16x1 channel among 16 requesters.
// Define MUX_SCHED_BURST_EN to allow up to BURST_LEN back-to-back beats per grant.
module mux16_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int unsigned N_REQ     = N_REQ_DEF,
    parameter int unsigned SEL_W     = SEL_W_DEF,
    parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    if (SEL_W != $clog2(N_REQ) || BURST_LEN < 1) begin : g_bad_cfg
        $error("mux16_rr_scheduler: inconsistent N_REQ/SEL_W/BURST_LEN");
    end

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [SEL_W-1:0] winner;
    logic             any_req;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req      (req),
        .last_ptr (last_q),
        .winner   (winner),
        .any_req  (any_req)
    );

`ifdef MUX_SCHED_BURST_EN
    localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel     <= '0;
            last_q  <= SEL_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            sel     <= sel_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel;
        last_d  = last_q;
`ifdef MUX_SCHED_BURST_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    sel_d   = winner;
`ifdef MUX_SCHED_BURST_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    state_d = IDLE;
                    last_d  = sel;
                end else if (out_ready) begin
`ifdef MUX_SCHED_BURST_EN
                    // A withdrawn request during a burst ends it via the abort branch above
                    if (cnt_q < CNT_W'(BURST_LEN - 1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        last_d  = sel;
                    end
`else
                    state_d = IDLE;
                    last_d  = sel;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == GRANT);
        out_valid = busy & req[sel];
        ack       = '0;
        if (out_valid && out_ready) begin
            ack[sel] = 1'b1;
        end
    end

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Directed self-checking bench for mux16_rr_scheduler (table vectors plus multi-cycle sequences).
module tb_mux16_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] ack;
    logic [3:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux16_rr_scheduler #(
        .N_REQ     (16),
        .SEL_W     (4),
        .BURST_LEN (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] req;
        logic        rdy;
        logic [3:0]  sel;
        logic        valid;
        logic [15:0] ack;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] r, input logic rd, input logic [3:0] s,
                       input logic v, input logic [15:0] a, input logic b);
        vec_t t;
        t.req = r; t.rdy = rd; t.sel = s; t.valid = v; t.ack = a; t.busy = b;
        vecs.push_back(t);
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] s, input logic v,
                                 input logic [15:0] a, input logic b);
        check({tag, ".sel"},       32'(sel), 32'(s));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".ack"},       32'(ack), 32'(a));
        check({tag, ".busy"},      32'(busy), 32'(b));
    endtask

    int          ack_cnt [16];
    logic [3:0]  exp_sel;

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;

        // single requester, round-robin pair 0/15, stall, late lower-index req, abort
        add(16'h0001, 1, 4'd0,  0, 16'h0000, 0);
        add(16'h0001, 1, 4'd0,  1, 16'h0001, 1);
        add(16'h8001, 1, 4'd0,  0, 16'h0000, 0);
        add(16'h8001, 1, 4'd15, 1, 16'h8000, 1);
        add(16'h8001, 1, 4'd15, 0, 16'h0000, 0);
        add(16'h8001, 1, 4'd0,  1, 16'h0001, 1);
        add(16'h8001, 1, 4'd0,  0, 16'h0000, 0);
        add(16'h8001, 1, 4'd15, 1, 16'h8000, 1);
        add(16'h0020, 0, 4'd15, 0, 16'h0000, 0);
        for (int i = 0; i < 10; i++)
            add((i == 0) ? 16'h0020 : 16'h0028, 0, 4'd5, 1, 16'h0000, 1);
        add(16'h0028, 1, 4'd5,  1, 16'h0020, 1);
        add(16'h0008, 1, 4'd5,  0, 16'h0000, 0);
        add(16'h0008, 1, 4'd3,  1, 16'h0008, 1);
        add(16'h0080, 0, 4'd3,  0, 16'h0000, 0);
        add(16'h0080, 0, 4'd7,  1, 16'h0000, 1);
        add(16'h0000, 0, 4'd7,  0, 16'h0000, 1);
        add(16'h0181, 1, 4'd7,  0, 16'h0000, 0);
        add(16'h0181, 1, 4'd8,  1, 16'h0100, 1);
        add(16'h0000, 1, 4'd8,  0, 16'h0000, 0);

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 4'd0, 0, 16'h0000, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            req       = vecs[i].req;
            out_ready = vecs[i].rdy;
            #2;
            check_outputs($sformatf("vec%0d", i), vecs[i].sel, vecs[i].valid, vecs[i].ack, vecs[i].busy);
            @(posedge clk);
            #1;
        end

        // reset asserted mid-GRANT (sel=9) clears outputs without waiting for an edge
        req       = 16'h0200;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("midrst.pre_sel",   32'(sel), 32'd9);
        check("midrst.pre_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("midrst", 4'd0, 0, 16'h0000, 0);

        // all requesters held: grants walk 0..15 and wrap, one beat per two cycles
        req = 16'hFFFF;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_sel = 4'd0;
        foreach (ack_cnt[i]) ack_cnt[i] = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc % 2 == 0) begin
                check($sformatf("ffff%0d.idle_valid", cyc), 32'(out_valid), 32'd0);
            end else begin
                check($sformatf("ffff%0d.sel", cyc), 32'(sel), 32'(exp_sel));
                check($sformatf("ffff%0d.ack", cyc), 32'(ack), 32'(16'h0001 << exp_sel));
                exp_sel = exp_sel + 4'd1;
            end
            check($sformatf("ffff%0d.onehot", cyc), 32'($countones(ack) <= 1), 32'd1);
            for (int b = 0; b < 16; b++) if (ack[b]) ack_cnt[b]++;
            if (cyc == 31) begin
                for (int b = 0; b < 16; b++)
                    check($sformatf("ffff.ack_count%0d", b), 32'(ack_cnt[b]), 32'd1);
            end
            @(posedge clk);
            #1;
        end

`ifdef MUX_SCHED_BURST_EN
        // last grant above was index 3; req[2] alone gets four back-to-back beats
        req       = 16'h0004;
        out_ready = 1'b1;
        #1;
        check_outputs("burst.idle0", 4'd3, 0, 16'h0000, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check_outputs($sformatf("burst.beat%0d", k), 4'd2, 1, 16'h0004, 1);
        end
        @(posedge clk);
        #1;
        check_outputs("burst.gap", 4'd2, 0, 16'h0000, 0);
        @(posedge clk);
        #1;
        check_outputs("burst.regrant", 4'd2, 1, 16'h0004, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux16_rr_scheduler.md
Name: mux16_rr_scheduler

Overview:
- Round-robin arbiter and sequencer that shares one 16:1 mux output channel among 16 requesters.
- Drives the 4-bit select of the mux16x1 tree and runs a req/ack handshake toward requesters and a valid/ready handshake toward the consumer.
- The data path stays external: consumer data = mux16x1(in, sel).

Parameters:
- N_REQ, 16, number of requesters; must equal the mux input count.
- SEL_W, 4, select width; must equal clog2(N_REQ).
- BURST_LEN, 4, maximum consecutive beats per grant; used only when MUX_SCHED_BURST_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester request; held high with data stable until ack.
- ack  output  N_REQ  one-hot pulse; requester's beat was accepted this cycle.
- sel  output  SEL_W  registered select to mux16x1.
- out_valid  output  1  mux output carries a valid beat.
- out_ready  input  1  consumer accepts the beat when out_valid is also high.
- busy  output  1  high while state is GRANT.

Behaviour:
- Reset (async assert, sync release): state=IDLE, sel=0, last_ptr=N_REQ-1 so index 0 has first priority, out_valid=0, ack=0, busy=0.
- IDLE, req==0: stay in IDLE; outputs unchanged except out_valid=0.
- IDLE, req!=0: winner = first set req bit scanning last_ptr+1, last_ptr+2, ... modulo N_REQ. On the next edge: sel<=winner, state<=GRANT. Request-to-valid latency is 1 cycle.
- GRANT outputs: out_valid=1, busy=1. ack = one-hot(sel) & {N_REQ{out_valid & out_ready & req[sel]}}, combinational. sel is stable for the whole GRANT.
- GRANT, out_ready=1 and req[sel]=1: beat transfers. ack[sel] pulses for that cycle, last_ptr<=sel, state<=IDLE.
- GRANT, req[sel]=0 (withdrawn, regardless of out_ready): abort. out_valid is forced 0 that cycle, no ack, last_ptr<=sel, state<=IDLE.
- GRANT, out_ready=0: hold state, sel and out_valid indefinitely. A new or higher-priority req cannot preempt.
- Throughput is one beat per 2 cycles: a mandatory IDLE cycle separates grants.
- Wrap-around: after last_ptr=15 the scan resumes at index 0.
- Only one requester active: it is re-granted on every IDLE pass.
- Reset asserted mid-GRANT: immediately return to reset values; any pending beat is dropped with no ack.
- ack is never multi-hot. out_valid never rises without a registered sel.

Optional Feature:
- Macro: MUX_SCHED_BURST_EN.
- Defined: a beat counter (width clog2(BURST_LEN)+1) resets to 0 on entry to GRANT. After each accepted beat, stay in GRANT with the same sel if req[sel] is still high and the count is below BURST_LEN-1. Otherwise go to IDLE and update last_ptr. Back-to-back beats within a burst run one per cycle.
- Undefined: exactly one beat per grant as described above; the counter logic and BURST_LEN are unused.

Decomposition:
- Package mux_sched_pkg:
  - state enum {IDLE, GRANT}
  - N_REQ and SEL_W defaults
  - BURST_LEN default
- Sub-module rr_pick (combinational): inputs req and last_ptr; outputs winner index and any_req. Implemented as rotate, fixed-priority encode, then add offset modulo N_REQ.

Test Plan:
- Reset, then req=16'h0001, out_ready=1: out_valid rises 1 cycle after req; sel=0; ack=16'h0001 on the transfer cycle; returns to IDLE.
- req=16'hFFFF held, out_ready=1, 40 cycles: sel sequence 0,1,2,...,15,0,1,...; each ack bit exactly once per 32 cycles; never multi-hot.
- req=16'h8001, last_ptr=15: grant order 0,15,0,15.
- Grant 5 with out_ready=0 for 10 cycles, then 1: sel=5 and out_valid=1 held for all 10 cycles; a new req[3] during the stall is not served until after ack[5].
- Grant 7, drop req[7] while out_ready=0: out_valid falls that cycle, no ack, next grant starts from index 8.
- rst_n low mid-GRANT (sel=9): out_valid=0, sel=0, ack=0 immediately. With MUX_SCHED_BURST_EN, BURST_LEN=4, req[2] held: four consecutive ack[2] pulses, then one IDLE cycle.
